mul_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the `ALU_MUL` operation of the CPU datapath. It detects a multiply in the ALU control code produced by ALU control, stalls the PC and pipeline, and runs an iterative shift-add multiply over up to 32 cycles. It then presents the low 32 bits of the product for write-back. Every non-MUL ALU operation passes untouched through the existing single-cycle ALU path.

---
 rtl/mul_seq_ctrl.sv | 90 +++++++++
 tb/tb_mul_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add sequencer for ALU_MUL: stalls the pipeline, iterates, pulses done_o.
// Optional macro MUL_EARLY_TERM_EN ends the iteration once the remaining multiplier bits are zero.

`ifndef ALU_MUL
`define ALU_MUL 3'b110
`endif

module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             mul_req;
  logic             last_iter;

  assign mul_req = valid_i && (ALUCtrl_i == `ALU_MUL);

`ifdef MUL_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain after this iteration's shift.
  assign last_iter = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
  assign last_iter = (cnt == CNT_LAST);
`endif

  // NOTE: all state lives in this one clocked block and uses <= so every
  // register sees the pre-edge values of the others (acc adds the old mcand).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_req) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_i so a MUL presented during reset never freezes the pipeline.
  assign stall_o  = !rst_i && (((state == IDLE) && mul_req) || (state == BUSY));
  assign result_o = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed steps plus randomized MULs
// checked against an arithmetic reference model of product and latency.

`ifndef ALU_MUL
`define ALU_MUL 3'b110
`endif

module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = `ALU_MUL;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  int tests = 0;
  int fails = 0;

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: product modulo 2^WIDTH via a double-width multiply.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[31:0];
  endfunction

  // Reference: number of BUSY cycles for a given multiplier.
  function automatic int model_busy(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) msb = i;
    return msb + 1;
`else
    return WIDTH + 0 * int'(b[0]);
`endif
  endfunction

  // Starts a MUL in the current low clock phase, follows it to done_o and
  // returns one low phase after the done cycle.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input bit keep, input bit wiggle, input string tag);
    int          busy;
    int          cyc;
    int          stalls;
    bit          seen;
    logic [31:0] exp;
    exp       = model_mul(a, b);
    busy      = model_busy(b);
    valid_i   = 1'b1;
    ALUCtrl_i = ALU_MUL;
    data1_i   = a;
    data2_i   = b;
    cyc       = 0;
    stalls    = 0;
    seen      = 1'b0;
    while (cyc < 100 && !seen) begin
      #1;
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (stall_o) stalls++;
        @(negedge clk_i);
        cyc++;
        if (wiggle) begin
          data1_i = $urandom;
          data2_i = $urandom;
          if ($urandom_range(0, 1) == 1) valid_i = 1'b0;
        end
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc, busy + 1);
    check({tag, "_stall_cycles"}, stalls, busy + 1);
    check({tag, "_stall_at_done"}, 32'(stall_o), 32'd0);
    check({tag, "_result"}, result_o, exp);
    if (!keep) valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones;
    rst_i     = 1'b1;
    valid_i   = 1'b0;
    ALUCtrl_i = ALU_ADD;
    data1_i   = '0;
    data2_i   = '0;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    valid_i   = 1'b1;
    ALUCtrl_i = ALU_MUL;
    #1;
    check("rst_stall_forced", 32'(stall_o), 32'd0);
    valid_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Non-MUL operation passes through without stalling.
    valid_i   = 1'b1;
    ALUCtrl_i = ALU_ADD;
    data1_i   = 32'd11;
    data2_i   = 32'd22;
    repeat (3) begin
      #1;
      check("add_no_stall", 32'(stall_o), 32'd0);
      check("add_no_done", 32'(done_o), 32'd0);
      @(negedge clk_i);
    end
    check("add_result_held", result_o, 32'd0);
    valid_i = 1'b0;
    @(negedge clk_i);

    run_mul(32'd7, 32'd6, 1'b0, 1'b0, "mul_7x6");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mul_ones");
    run_mul(32'h8000_0000, 32'd2, 1'b0, 1'b0, "mul_carry");
    run_mul(32'h1234_5678, 32'd0, 1'b0, 1'b0, "mul_zero");
    run_mul(32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, "mul_one");

    // Back-to-back: second MUL is seen in IDLE the cycle after done_o.
    run_mul(32'd3, 32'd5, 1'b1, 1'b0, "b2b_first");
    check("b2b_stall_next", 32'(stall_o), 32'd1);
    run_mul(32'd10, 32'd10, 1'b0, 1'b0, "b2b_second");

    // Randomized operands, with inputs scrambled and valid_i dropped while busy.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = b >> $urandom_range(0, 31);
      run_mul(a, b, 1'b0, (i % 2) == 1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of BUSY aborts the operation without a pulse.
    valid_i   = 1'b1;
    ALUCtrl_i = ALU_MUL;
    data1_i   = 32'd9;
    data2_i   = 32'hFFFF_FFFF;
    repeat (11) @(negedge clk_i);
    #1;
    check("abort_busy_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("abort_stall_drop", 32'(stall_o), 32'd0);
    check("abort_done_drop", 32'(done_o), 32'd0);
    check("abort_result_clr", result_o, 32'd0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      #1;
      if (done_o) dones++;
    end
    check("abort_no_done", dones, 0);
    @(negedge clk_i);
    run_mul(32'd2, 32'd3, 1'b0, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
